piece_bag_generator: RTL
========================

Name: piece_bag_generator

Overview:
Upstream source of shape IDs for the piece-pattern decoder stage. Uses a free-running 16-bit LFSR and 7-bag randomisation: every run of 7 consecutive pieces is a permutation of the 7 tetrominoes. Holds the current piece and a one-deep preview, and never emits ID 7. The game-control FSM requests a new piece on each spawn.

Parameters:
SEED, 16'hACE1, LFSR reset value; 0 is illegal and is replaced by 16'h0001.
MAX_TRIES, 8, maximum LFSR samples per draw before the deterministic fallback; legal range 1..15.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous, active-low reset
req  input  1  spawn request; sampled only when ready=1
ready  output  1  cur_shape_id and next_shape_id are valid and req will be accepted
cur_shape_id  output  3  piece to spawn now (0..6)
next_shape_id  output  3  preview piece (0..6)

Behaviour:
- Reset is asynchronous, active-low. While rst_n=0: ready=0, cur_shape_id=0, next_shape_id=0, bag_mask=7'h7F, lfsr=SEED (or 16'h0001 if SEED==0), try_cnt=0, state=FILL_CUR.
- LFSR: Galois, polynomial x^16+x^14+x^13+x^11+1. It advances every clock out of reset, independent of state. The candidate is lfsr[2:0].
- avail = (bag_mask==0) ? 7'h7F : bag_mask. The bag refills lazily at the first draw after it empties.
- Draw cycle, in states FILL_CUR and FILL_NEXT:
  - Valid candidate (candidate!=7 and avail[candidate]=1): take the candidate.
  - Otherwise, if try_cnt==MAX_TRIES-1: take the lowest set bit index of avail (fallback).
  - Otherwise: try_cnt++ and stay in the state.
  - On a take: bag_mask <= avail with the taken bit cleared, and try_cnt <= 0.
  - A draw therefore completes in 1..MAX_TRIES cycles.
- States:
  - FILL_CUR: on take, cur_shape_id <= id, then go to FILL_NEXT.
  - FILL_NEXT: on take, next_shape_id <= id, ready <= 1, then go to READY.
  - READY: if req=1, cur_shape_id <= next_shape_id and ready <= 0 (registered, so ready is low from the following cycle), then go to FILL_NEXT. If req=0, hold.
- Latency:
  - Reset release to ready=1: 2..2*MAX_TRIES clock edges.
  - Accepted req to ready=1: 1..MAX_TRIES edges after the edge that accepted it.
- req while ready=0 is ignored; it is not queued. Holding req high gives exactly one advance per READY visit.
- cur_shape_id and next_shape_id are stable whenever ready=1. next_shape_id is not meaningful while ready=0.
- Reset mid-draw aborts immediately; the partial bag is discarded. Behaviour is fully deterministic per SEED.
- Outputs never take the value 7.

Decomposition:
- tetris_pkg holds:
  - SHAPE_W=3, NUM_SHAPES=7.
  - Shape constants SHAPE_O=0, SHAPE_I=1, SHAPE_T=2, SHAPE_L=3, SHAPE_J=4, SHAPE_S=5, SHAPE_Z=6.
  - State encoding FILL_CUR/FILL_NEXT/READY.
  - LFSR_TAPS=16'hB400.
- One sub-module, galois_lfsr16: ports clk, rst_n, seed, q[15:0]; always enabled.
- Bag mask, try counter and FSM stay in the top.

Test Plan:
1. Default params, rst_n low for 3 cycles, then high: during reset ready=0, cur=0, next=0; ready=1 within 16 edges of release; cur!=next; neither output is 7.
2. After ready, issue 14 single-cycle req pulses, each only when ready=1, and log cur_shape_id at each accept: entries 1-7 and entries 8-14 are each a permutation of {0..6}.
3. MAX_TRIES=1: ready=1 exactly 2 edges after release. Every draw takes 1 cycle. If the first candidate is 7 or already used, the lowest available ID is taken (first draw then gives cur=0).
4. req held high for 40 cycles: cur changes exactly once per ready high-to-low transition; ready is low for 1..MAX_TRIES cycles after each accept; no 7 appears.
5. Assert rst_n low during FILL_NEXT: all outputs go to reset values immediately, without a clock edge. After release, the piece sequence exactly matches scenario 1 and 2 for the same SEED.
6. SEED=16'h0000: the LFSR loads 16'h0001, never sticks at 0, and ready rises within 16 edges; 50 reqs all yield IDs in 0..6 with bag property intact.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared shape IDs, bag FSM states and LFSR constants
// for the piece source and the pattern decoder.
package tetris_pkg;

    localparam int SHAPE_W    = 3;
    localparam int NUM_SHAPES = 7;

    typedef logic [SHAPE_W-1:0] shape_t;

    localparam shape_t SHAPE_O = 3'd0;
    localparam shape_t SHAPE_I = 3'd1;
    localparam shape_t SHAPE_T = 3'd2;
    localparam shape_t SHAPE_L = 3'd3;
    localparam shape_t SHAPE_J = 3'd4;
    localparam shape_t SHAPE_S = 3'd5;
    localparam shape_t SHAPE_Z = 3'd6;

    typedef enum logic [1:0] {
        FILL_CUR  = 2'd0,
        FILL_NEXT = 2'd1,
        READY     = 2'd2
    } bag_state_e;

    // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        lfsr_next = s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    function automatic shape_t lowest_avail(
        input logic [NUM_SHAPES-1:0] m
    );
        lowest_avail = SHAPE_O;
        for (int k = NUM_SHAPES - 1; k >= 0; k--) begin
            if (m[k]) begin
                lowest_avail = SHAPE_W'(k);
            end
        end
    endfunction

endpackage

// File: rtl/galois_lfsr16.sv
// Free-running 16-bit Galois LFSR; a zero seed would lock up,
// so it is replaced by 1.
module galois_lfsr16
    import tetris_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;
    logic [15:0] seed_eff;

    always_comb begin
        seed_eff = (seed == 16'h0000) ? 16'h0001 : seed;
        q_d      = lfsr_next(q_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= seed_eff;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/piece_bag_generator.sv
// 7-bag shape source: current piece plus one-deep preview,
// drawn from an LFSR with a bounded retry and lowest-free fallback.
module piece_bag_generator
    import tetris_pkg::*;
#(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          MAX_TRIES = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req,
    output logic         ready,
    output logic [2:0]   cur_shape_id,
    output logic [2:0]   next_shape_id
);

    localparam logic [3:0] LAST_TRY = 4'(MAX_TRIES - 1);

    logic [15:0]           lfsr_q;
    logic [12:0]           lfsr_unused;

    bag_state_e            state_q;
    bag_state_e            state_d;
    logic [NUM_SHAPES-1:0] bag_q;
    logic [NUM_SHAPES-1:0] bag_d;
    logic [3:0]            try_q;
    logic [3:0]            try_d;
    shape_t                cur_q;
    shape_t                cur_d;
    shape_t                next_q;
    shape_t                next_d;
    logic                  ready_q;
    logic                  ready_d;

    logic [NUM_SHAPES-1:0] avail;
    logic [NUM_SHAPES:0]   avail_ext;
    shape_t                cand;
    logic                  cand_ok;
    shape_t                draw_id;
    logic                  in_fill;
    logic                  take;

    galois_lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .seed  (SEED),
        .q     (lfsr_q)
    );

    assign lfsr_unused = lfsr_q[15:3];

    always_comb begin
        avail     = (bag_q == '0) ? {NUM_SHAPES{1'b1}} : bag_q;
        // bit 7 is always clear, so candidate 7 can never qualify
        avail_ext = {1'b0, avail};
        cand      = lfsr_q[2:0];
        cand_ok   = avail_ext[cand];
        draw_id   = cand_ok ? cand : lowest_avail(avail);
        in_fill   = (state_q == FILL_CUR) || (state_q == FILL_NEXT);
        take      = in_fill && (cand_ok || (try_q == LAST_TRY));
    end

    always_comb begin
        state_d = state_q;
        bag_d   = bag_q;
        try_d   = try_q;
        cur_d   = cur_q;
        next_d  = next_q;
        ready_d = ready_q;

        if (in_fill) begin
            if (take) begin
                bag_d = avail & ~(NUM_SHAPES'(1) << draw_id);
                try_d = '0;
            end else begin
                try_d = try_q + 4'd1;
            end
        end

        unique case (state_q)
            FILL_CUR: begin
                if (take) begin
                    cur_d   = draw_id;
                    state_d = FILL_NEXT;
                end
            end
            FILL_NEXT: begin
                if (take) begin
                    next_d  = draw_id;
                    ready_d = 1'b1;
                    state_d = READY;
                end
            end
            READY: begin
                if (req) begin
                    cur_d   = next_q;
                    ready_d = 1'b0;
                    state_d = FILL_NEXT;
                end
            end
            default: begin
                ready_d = 1'b0;
                state_d = FILL_CUR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL_CUR;
            bag_q   <= {NUM_SHAPES{1'b1}};
            try_q   <= '0;
            cur_q   <= SHAPE_O;
            next_q  <= SHAPE_O;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bag_q   <= bag_d;
            try_q   <= try_d;
            cur_q   <= cur_d;
            next_q  <= next_d;
            ready_q <= ready_d;
        end
    end

    assign ready         = ready_q;
    assign cur_shape_id  = cur_q;
    assign next_shape_id = next_q;

endmodule
